// File: rtl/accum_alu_if.sv
// Command/status bundle of the accumulator ALU. The master issues commands,
// the slave (accum_alu) executes them and reports accumulator and state.
interface accum_alu_if #(
    parameter int WIDTH = 8
);
    // Handshake: a command (op, operand) transfers on a rising clk edge where
    // cmd_valid and cmd_ready are both 1. cmd_ready does not depend on
    // cmd_valid, and op/operand are only looked at while cmd_valid is 1.
    logic             en;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic             clear_err;
    logic [WIDTH-1:0] acc;
    logic             result_valid;
    logic             error;
    logic [1:0]       state;

    modport master (
        output en, cmd_valid, op, operand, clear_err,
        input  cmd_ready, acc, result_valid, error, state
    );

    modport slave (
        input  en, cmd_valid, op, operand, clear_err,
        output cmd_ready, acc, result_valid, error, state
    );
endinterface

// File: rtl/accum_alu.sv
// Accumulator ALU: single-cycle logic/arithmetic ops on a registered
// accumulator, plus a WIDTH-cycle shift-add multiply and an overflow ERROR state.
module accum_alu #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    accum_alu_if.slave bus
);
    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               valid_q, valid_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [2*WIDTH-1:0] prod_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            valid_q  <= valid_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        accept    = (state_q == S_READY) && bus.cmd_valid;
        // Extra top bit of the sum is the carry, of the difference the borrow.
        sum_ext   = {1'b0, acc_q} + {1'b0, bus.operand};
        diff_ext  = {1'b0, acc_q} - {1'b0, bus.operand};
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_OFF: begin
                if (bus.en) state_d = S_READY;
            end
            S_READY: begin
                if (accept) begin
                    valid_d = (bus.op != OP_MUL);
                    case (bus.op)
                        OP_AND:  acc_d = acc_q & bus.operand;
                        OP_OR:   acc_d = acc_q | bus.operand;
                        OP_XOR:  acc_d = acc_q ^ bus.operand;
                        OP_NOT:  acc_d = ~acc_q;
                        OP_ADD: begin
                            acc_d = sum_ext[WIDTH-1:0];
                            if (sum_ext[WIDTH]) state_d = S_ERROR;
                        end
                        OP_SUB: begin
                            acc_d = diff_ext[WIDTH-1:0];
                            if (diff_ext[WIDTH]) state_d = S_ERROR;
                        end
                        OP_MUL: begin
                            state_d  = S_RUN;
                            prod_d   = '0;
                            mcand_d  = {{WIDTH{1'b0}}, acc_q};
                            mplier_d = bus.operand;
                            cnt_d    = '0;
                        end
                        OP_LOAD: acc_d = bus.operand;
                        default: acc_d = acc_q;
                    endcase
                end else if (!bus.en) begin
                    state_d = S_OFF;
                end
            end
            S_RUN: begin
                // One multiplier bit per cycle; acc only changes on the last one.
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    acc_d   = prod_step[WIDTH-1:0];
                    valid_d = 1'b1;
                    state_d = (|prod_step[2*WIDTH-1:WIDTH]) ? S_ERROR : S_READY;
                end
            end
            S_ERROR: begin
                if (bus.clear_err) state_d = S_READY;
            end
            default: state_d = S_OFF;
        endcase
    end

    assign bus.cmd_ready    = (state_q == S_READY);
    assign bus.error        = (state_q == S_ERROR);
    assign bus.state        = state_q;
    assign bus.acc          = acc_q;
    assign bus.result_valid = valid_q;
endmodule

// File: doc/accum_alu.md
ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the accumulator and operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit, the power-on request.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit, which marks op/operand as valid.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit, meaning a command is accepted this cycle.
REQ-007 The block SHALL have port op, input, 3 bits, encoded 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MUL, 7 LOAD.
REQ-008 The block SHALL have port operand, input, WIDTH bits, the second operand (unsigned).
REQ-009 The block SHALL have port clear_err, input, 1 bit, the error acknowledge.
REQ-010 The block SHALL have port acc, output, WIDTH bits, the registered accumulator.
REQ-011 The block SHALL have port result_valid, output, 1 bit, a one-cycle pulse that marks acc as newly updated.
REQ-012 The block SHALL have port error, output, 1 bit, high when the state is ERROR.
REQ-013 The block SHALL have port state, output, 2 bits, encoded OFF=00, READY=01, RUN=10, ERROR=11.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal (state==READY).
REQ-015 In OFF, en=1 SHALL move the state to READY on the next edge; otherwise the state SHALL stay OFF.
REQ-016 In READY with no accepted command, en=0 SHALL move the state to OFF with acc retained; en SHALL be ignored in RUN and ERROR.
REQ-017 On acceptance in READY, single-cycle ops SHALL write acc at that edge as follows:
- AND: acc & operand
- OR: acc | operand
- XOR: acc ^ operand
- NOT: ~acc, operand ignored
- LOAD: operand
REQ-018 ADD SHALL write acc = (acc+operand) mod 2^WIDTH; a carry-out SHALL move the state to ERROR, otherwise the state SHALL stay READY.
REQ-019 SUB SHALL write acc = (acc-operand) mod 2^WIDTH; a borrow (operand > acc) SHALL move the state to ERROR, otherwise the state SHALL stay READY.
REQ-020 MUL acceptance SHALL latch both operands and enter RUN; RUN SHALL perform an iterative shift-add of one bit per cycle for exactly WIDTH cycles, with acc unchanged meanwhile.
REQ-021 On the edge ending the WIDTH-th RUN cycle, acc SHALL take product[WIDTH-1:0]; the state SHALL go to ERROR if product[2*WIDTH-1:WIDTH] is nonzero, otherwise to READY.
REQ-022 result_valid SHALL be high for exactly the one cycle after each acc write (single-cycle ops, and MUL completion); the MUL result SHALL therefore be visible WIDTH+1 cycles after acceptance.
REQ-023 In ERROR, clear_err=1 SHALL move the state to READY on the next edge, with acc retained; cmd_valid SHALL be ignored while in ERROR.
REQ-024 An overflowing result SHALL still be written to acc; only the state and error flag indicate the overflow.

Reset
REQ-025 rst=1 SHALL take priority over all other inputs in every state, including mid-MUL, where it aborts the multiply with no result_valid pulse.
REQ-026 After a reset edge, the outputs SHALL be: state=OFF, acc=0, result_valid=0, error=0, cmd_ready=0, and the internal multiplier registers cleared.

Verification (WIDTH=8)
REQ-027 The bench SHALL cover: rst, en=1, LOAD 0x3C, then AND 0x0F -> acc=0x0C, result_valid pulse after each command, state=READY.
REQ-028 The bench SHALL cover: LOAD 0xF0, ADD 0x20 -> acc=0x10, state=ERROR, error=1, cmd_ready=0; then clear_err -> READY, acc=0x10.
REQ-029 The bench SHALL cover: LOAD 0x0C, MUL 0x0A -> state=RUN for 8 cycles with cmd_ready=0, then acc=0x78, result_valid for 1 cycle, state=READY.
REQ-030 The bench SHALL cover: LOAD 0x20, MUL 0x10 -> acc=0x00, state=ERROR; also LOAD 0x03, SUB 0x05 -> acc=0xFE, state=ERROR.
REQ-031 The bench SHALL cover: rst asserted on the 3rd RUN cycle of a MUL -> next cycle state=OFF, acc=0x00, no result_valid.
REQ-032 The bench SHALL cover: en=0 during MUL -> MUL completes, state=READY, then OFF on the next edge with acc retained; cmd_valid held high in OFF is not accepted.
